lh_msg_padder: RTL and testbench
================================

Name: lh_msg_padder

Overview:
Upstream stage of the light-hash (AES S-box) core. Accepts a raw message byte stream, passes message bytes through, and appends the padding and length trailer so the core always receives whole BLOCK_BYTES blocks. It uses valid/ready handshakes on both sides and a registered output, and it also terminates each message for the core's finalisation logic.

Parameters:
BLOCK_BYTES, 8, hash block size in bytes; must be greater than LEN_BYTES+1.
LEN_BYTES, 2, width of the length trailer in bytes; length is a byte count, big-endian.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  reset, asynchronous, active-high.
in_byte  input  8  message byte.
in_valid  input  1  in_byte is valid.
in_last  input  1  in_byte is the final byte of the message; sampled with in_valid.
in_ready  output  1  block accepts in_byte this cycle.
out_byte  output  8  byte to the hash core.
out_valid  output  1  out_byte is valid.
out_last  output  1  out_byte is the final byte of the padded message.
out_ready  input  1  hash core accepts out_byte.

Behaviour:
- Reset values: out_valid=0, out_byte=8'h00, out_last=0, state=PASS, pos=0, len=0. in_ready is combinational and evaluates to 1 after reset.
- Output register: a transfer occurs when out_valid && out_ready. While out_valid && !out_ready, out_byte and out_last hold stable. The register loads when !out_valid || out_ready (the "load" condition).
- Input transfer occurs on in_valid && in_ready. in_ready = (state==PASS) && load. Latency from input to output is 1 cycle; full throughput is 1 byte/cycle.
- pos counts 0..BLOCK_BYTES-1 and wraps. It increments on every byte loaded into the output register, including padding bytes.
- len counts accepted message bytes modulo 2^(8*LEN_BYTES) and wraps silently.
- FSM states: PASS, PAD80, ZERO, LEN, DONE.
  - PASS: forward in_byte on an input transfer. If in_last, go to PAD80.
  - PAD80: on load, emit 8'h80. If the new pos (after increment) equals BLOCK_BYTES-LEN_BYTES, go to LEN; otherwise go to ZERO.
  - ZERO: on load, emit 8'h00. When the new pos equals BLOCK_BYTES-LEN_BYTES, go to LEN. The zero run continues across a block wrap when 0x80 landed at or after index BLOCK_BYTES-LEN_BYTES, which produces one extra block.
  - LEN: on load, emit length byte k = 0..LEN_BYTES-1, MSB first. The final byte sets out_last=1; go to DONE.
  - DONE: once the out_last byte has transferred, clear pos and len and return to PASS.
- in_ready=0 in every state except PASS.
- Boundaries:
  - A message whose length ≡ BLOCK_BYTES-LEN_BYTES-1 mod BLOCK_BYTES puts 0x80 immediately before the length trailer with no zeros.
  - Zero-length messages are not supported; every message has at least one byte.
  - in_last without in_valid is ignored.
  - Back-to-back messages: the first byte of the next message is accepted in the cycle after DONE clears.
  - Reset asserted mid-message: everything returns to reset values immediately, and the partial message is discarded.
- Arithmetic: length bytes are len[8*(LEN_BYTES-1-k) +: 8].

Optional Feature:
LH_PAD_LEN_ERR_EN
- Defined: adds output err_len_overflow (1 bit, reset 0). It is set when len wraps from all-ones to zero during PASS, stays sticky until the message's out_last transfer, and is cleared in DONE. Padding is unaffected.
- Undefined: the port is absent and len wraps silently.

Decomposition:
- Shared package lh_pkg holds:
  - LH_BLOCK_BYTES=8 and LH_LEN_BYTES=2 defaults.
  - LH_PAD_BYTE=8'h80.
  - typedef enum logic [2:0] lh_pad_state_t {PASS, PAD80, ZERO, LEN, DONE}.
- One sub-module, lh_byte_reg_slice: the 8+1-bit output register with valid/ready hold logic. It is reused later on the digest output side.

Test Plan:
1. "abc" (61 62 63, last on 63), out_ready=1 -> out: 61 62 63 80 00 00 00 03, out_last only on 03, 8 bytes total.
2. 5 bytes 01..05 -> 01 02 03 04 05 80 00 05, with no zero bytes between 80 and the length.
3. 6 bytes 01..06 -> 01..06 80 00, then 00×6 00 06; 16 bytes, out_last on byte 16.
4. "abc" with out_ready toggling 1,0,0,1... -> same byte sequence as scenario 1; out_byte stable while stalled; in_ready=0 during stalls and throughout padding.
5. Reset asserted after 2 bytes of a message, then "abc" sent -> output exactly as in scenario 1, with no residue of the aborted message.
6. With LH_PAD_LEN_ERR_EN defined, a 65537-byte message -> err_len_overflow rises on byte 65536, trailer length bytes 00 01, flag clears after out_last.

Source files
------------

// File: rtl/lh_pkg.sv
// rtl/lh_pkg.sv - shared defaults, pad byte and padder state type for the light-hash message path
package lh_pkg;

    localparam int         LH_BLOCK_BYTES = 8;
    localparam int         LH_LEN_BYTES   = 2;
    localparam logic [7:0] LH_PAD_BYTE    = 8'h80;

    typedef enum logic [2:0] {
        PASS,
        PAD80,
        ZERO,
        LEN,
        DONE
    } lh_pad_state_t;

endpackage

// File: rtl/lh_byte_reg_slice.sv
// rtl/lh_byte_reg_slice.sv - registered byte+last slice with valid/ready hold
// Used for the padded message stream and for the digest output stream.
module lh_byte_reg_slice (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_data,
    input  logic       i_last,
    input  logic       i_valid,
    output logic       o_ready,
    output logic [7:0] o_data,
    output logic       o_last,
    output logic       o_valid,
    input  logic       i_ready
);

    logic       r_valid;
    logic [7:0] r_data;
    logic       r_last;

    // The register may load whenever it is empty or its current byte is leaving.
    assign o_ready = !r_valid || i_ready;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_valid <= 1'b0;
            r_data  <= 8'h00;
            r_last  <= 1'b0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
                r_last <= i_last;
            end
        end
    end

    assign o_data  = r_data;
    assign o_last  = r_last;
    assign o_valid = r_valid;

endmodule

// File: rtl/lh_msg_padder.sv
// rtl/lh_msg_padder.sv - pass-through message padder appending 0x80, zeros and a big-endian length trailer
// Optional LH_PAD_LEN_ERR_EN adds the sticky err_len_overflow output.
module lh_msg_padder
    import lh_pkg::*;
#(
    parameter int BLOCK_BYTES = LH_BLOCK_BYTES,
    parameter int LEN_BYTES   = LH_LEN_BYTES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_byte,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] out_byte,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready
`ifdef LH_PAD_LEN_ERR_EN
    ,
    output logic       err_len_overflow
`endif
);

    localparam int              PW        = $clog2(BLOCK_BYTES);
    localparam int              LW        = 8 * LEN_BYTES;
    localparam logic [PW-1:0]   TRAIL_POS = PW'(BLOCK_BYTES - LEN_BYTES);
    localparam logic [PW-1:0]   LAST_POS  = PW'(BLOCK_BYTES - 1);
    localparam logic [PW-1:0]   LAST_K    = PW'(LEN_BYTES - 1);

    lh_pad_state_t r_state;
    lh_pad_state_t w_state_nxt;
    logic [PW-1:0] r_pos;
    logic [PW-1:0] w_pos_nxt;
    logic [PW-1:0] w_k;
    logic [LW-1:0] r_len;
    logic          w_load;
    logic          w_push;
    logic          w_out_done;
    logic          w_src_valid;
    logic          w_src_last;
    logic [7:0]    w_src_byte;

    assign in_ready   = (r_state == PASS) && w_load;
    assign w_push     = w_src_valid && w_load;
    assign w_out_done = out_valid && out_ready && out_last;
    assign w_pos_nxt  = (r_pos == LAST_POS) ? '0 : r_pos + 1'b1;
    assign w_k        = r_pos - TRAIL_POS;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= PASS;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_pos <= '0;
            r_len <= '0;
        end else if (r_state == DONE) begin
            if (w_out_done) begin
                r_pos <= '0;
                r_len <= '0;
            end
        end else if (w_push) begin
            r_pos <= w_pos_nxt;
            if (r_state == PASS) begin
                r_len <= r_len + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            PASS:    if (w_push && in_last) w_state_nxt = PAD80;
            PAD80:   if (w_push) w_state_nxt = (w_pos_nxt == TRAIL_POS) ? LEN : ZERO;
            ZERO:    if (w_push && (w_pos_nxt == TRAIL_POS)) w_state_nxt = LEN;
            LEN:     if (w_push && w_src_last) w_state_nxt = DONE;
            DONE:    if (w_out_done) w_state_nxt = PASS;
            default: w_state_nxt = PASS;
        endcase
    end

    // Byte source feeding the output register; the trailer index is the offset past TRAIL_POS.
    always_comb begin
        w_src_valid = 1'b0;
        w_src_byte  = 8'h00;
        w_src_last  = 1'b0;
        case (r_state)
            PASS: begin
                w_src_valid = in_valid;
                w_src_byte  = in_byte;
            end
            PAD80: begin
                w_src_valid = 1'b1;
                w_src_byte  = LH_PAD_BYTE;
            end
            ZERO: begin
                w_src_valid = 1'b1;
            end
            LEN: begin
                w_src_valid = 1'b1;
                for (int k = 0; k < LEN_BYTES; k++) begin
                    if (w_k == PW'(k)) begin
                        w_src_byte = r_len[8*(LEN_BYTES-1-k) +: 8];
                    end
                end
                w_src_last = (w_k == LAST_K);
            end
            default: ;
        endcase
    end

    lh_byte_reg_slice u_out_slice (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_data  (w_src_byte),
        .i_last  (w_src_last),
        .i_valid (w_src_valid),
        .o_ready (w_load),
        .o_data  (out_byte),
        .o_last  (out_last),
        .o_valid (out_valid),
        .i_ready (out_ready)
    );

`ifdef LH_PAD_LEN_ERR_EN
    logic r_err;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_err <= 1'b0;
        end else if ((r_state == DONE) && w_out_done) begin
            r_err <= 1'b0;
        end else if ((r_state == PASS) && w_push && (r_len == '1)) begin
            r_err <= 1'b1;
        end
    end

    assign err_len_overflow = r_err;
`endif

endmodule

// File: tb/tb_lh_msg_padder.sv
// tb/tb_lh_msg_padder.sv - scoreboard bench for lh_msg_padder with a queue-based padding model
module tb_lh_msg_padder;

    localparam int BB = 8;
    localparam int LB = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] in_byte = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       out_last;
    logic       out_ready = 1'b1;
`ifdef LH_PAD_LEN_ERR_EN
    logic       err_len_overflow;
`endif

    lh_msg_padder #(.BLOCK_BYTES(BB), .LEN_BYTES(LB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready)
`ifdef LH_PAD_LEN_ERR_EN
        ,
        .err_len_overflow (err_len_overflow)
`endif
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass = 0;
    logic [8:0] exp_q[$];
    logic [7:0] msg[$];
    bit         in_pad = 1'b0;
    int         ready_mode = 0;
    int         rdy_phase = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_byte = 8'h00;
    logic       prev_last = 1'b0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    endtask

    // Expected padded stream: message, 0x80, zeros up to the trailer slot, big-endian length.
    task automatic push_expected(input int n);
        int          cnt;
        logic [31:0] l;
        for (int i = 0; i < n; i++) exp_q.push_back({1'b0, msg[i]});
        exp_q.push_back({1'b0, 8'h80});
        cnt = n + 1;
        while ((cnt % BB) != (BB - LB)) begin
            exp_q.push_back(9'h000);
            cnt++;
        end
        l = 32'(n % (1 << (8 * LB)));
        for (int k = 0; k < LB; k++) exp_q.push_back({(k == LB - 1), 8'(l >> (8 * (LB - 1 - k)))});
    endtask

    task automatic wait_accept();
        bit acc = 1'b0;
        int guard = 0;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
            if (!acc && guard > 300) begin
                check(1'b0, "accept_timeout", 32'(guard), 32'd300);
                acc = 1'b1;
            end
        end
    endtask

    task automatic send_msg(input bit gaps);
        int n = msg.size();
        push_expected(n);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(3) == 0) begin
                    in_valid = 1'b0;
                    in_last  = 1'($urandom_range(1));
                    in_byte  = 8'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_byte  = msg[i];
            in_last  = (i == n - 1);
            wait_accept();
`ifdef LH_PAD_LEN_ERR_EN
            if (n > 65535 && i + 1 >= 65535 && i + 1 <= 65537)
                check(err_len_overflow == (i + 1 >= 65536), "err_len_overflow", 32'(err_len_overflow), 32'(i + 1 >= 65536));
`endif
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_pad   = 1'b1;
    endtask

    task automatic drain(input string name);
        int g = 0;
        while (exp_q.size() != 0 && g < 3000) begin
            @(posedge clk);
            #1;
            g++;
        end
        check(exp_q.size() == 0, name, 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic set_msg_seq(input logic [7:0] first, input int n);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(8'(first + 8'(i)));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = (rdy_phase % 3 == 0);
                    rdy_phase++;
                end
                default: out_ready = ($urandom_range(3) != 0);
            endcase
        end
    end

    // Monitor: pops the scoreboard on every output transfer and checks hold/ready rules.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    check(out_valid && out_byte == prev_byte && out_last == prev_last, "stall_hold",
                          32'({out_valid, out_last, out_byte}), 32'({1'b1, prev_last, prev_byte}));
                if (out_valid && !out_ready) check(!in_ready, "in_ready_stall", 32'(in_ready), 32'd0);
                if (in_pad) check(!in_ready, "in_ready_pad", 32'(in_ready), 32'd0);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_out", 32'({out_last, out_byte}), 32'h1ff);
                    end else begin
                        e = exp_q.pop_front();
                        check({out_last, out_byte} == e, "out_byte_last", 32'({out_last, out_byte}), 32'(e));
                    end
                    if (out_last) in_pad = 1'b0;
                end
                prev_stall = out_valid && !out_ready;
                prev_byte  = out_byte;
                prev_last  = out_last;
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check(out_valid == 1'b0, "rst_out_valid", 32'(out_valid), 32'd0);
        check(out_byte == 8'h00, "rst_out_byte", 32'(out_byte), 32'd0);
        check(out_last == 1'b0, "rst_out_last", 32'(out_last), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check(in_ready == 1'b1, "rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        send_msg(1'b0);
        drain("s1_abc");

        set_msg_seq(8'h01, 5);
        send_msg(1'b0);
        drain("s2_len5");

        set_msg_seq(8'h01, 6);
        send_msg(1'b0);
        drain("s3_len6");

        ready_mode = 1;
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        send_msg(1'b0);
        drain("s4_stall");
        ready_mode = 0;

        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h22});
        in_valid = 1'b1; in_byte = 8'h11; in_last = 1'b0;
        wait_accept();
        in_byte = 8'h22;
        wait_accept();
        in_valid = 1'b0;
        rst_n = 1'b1;
        exp_q.delete();
        #2;
        check(out_valid == 1'b0, "async_rst_valid", 32'(out_valid), 32'd0);
        check(out_byte == 8'h00, "async_rst_byte", 32'(out_byte), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        send_msg(1'b0);
        drain("s5_after_abort");

        ready_mode = 2;
        for (int m = 0; m < 30; m++) begin
            msg.delete();
            for (int i = 0; i < int'($urandom_range(20, 1)); i++) msg.push_back(8'($urandom));
            send_msg(1'b1);
        end
        drain("random_msgs");
        ready_mode = 0;

`ifdef LH_PAD_LEN_ERR_EN
        msg.delete();
        for (int i = 0; i < 65537; i++) msg.push_back(8'($urandom));
        send_msg(1'b0);
        drain("s6_overflow");
        check(err_len_overflow == 1'b0, "err_cleared", 32'(err_len_overflow), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
